// File: rtl/air_traffic_pkg.sv
// Shared encodings, FSM state type and small helpers for the runway/gate arbiter.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
//
// Contents: fuel codes, runway constants, FSM state enum, gate->runway
// mapping for departures, and the runway round-robin successor.
package air_traffic_pkg;

   localparam logic [1:0] FUEL_NORMAL = 2'b00;
   localparam logic [1:0] FUEL_SHORT  = 2'b01;
   localparam logic [1:0] FUEL_EXCESS = 2'b10;
   localparam logic [1:0] FUEL_RSVD   = 2'b11;   // decoded as normal

   localparam logic [1:0] RWY_EMERG = 2'd0;
   localparam logic [1:0] RWY_FIRST = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_GRANTED
   } atc_state_t;

   // Departures use the runway nearest their gate block.
   function automatic logic [1:0] gate_to_runway(input logic [2:0] gate);
      if (gate <= 3'd3)
         return 2'd1;
      else if (gate <= 3'd5)
         return 2'd2;
      else
         return 2'd3;
   endfunction

   // Landing runways rotate 1 -> 2 -> 3 -> 1; runway 0 is never in the rotation.
   function automatic logic [1:0] next_runway(input logic [1:0] rwy);
      return (rwy == 2'd3) ? RWY_FIRST : rwy + 2'd1;
   endfunction

endpackage

// File: rtl/air_traffic_ctrl_if.sv
// Tower status bus: aircraft request inputs and registered grant outputs.
// Latency: n/a (wiring only).
// Backpressure: none; requests are level signals sampled every cycle.
//
// master: request source / status consumer (tower side)
// slave : the arbiter (consumes requests, drives grant and timer status)
interface air_traffic_ctrl_if;

   logic       weather;          // 1 = good
   logic       speed;            // approach speed within limits
   logic       range;            // within landing range
   logic       altitude;         // approach altitude within limits
   logic [1:0] fuel;             // 00 normal, 01 shortage, 10 excess, 11 normal
   logic       emergency;        // declared emergency
   logic       takeoff_signal;   // takeoff request
   logic [2:0] gate_number;      // departing aircraft's gate
   logic [1:0] allocated_runway; // 0 = emergency runway
   logic [2:0] allocated_gate;   // 0 = none / released
   logic       timer_active;
   logic [3:0] timer_value;

   modport master (
      output weather, speed, range, altitude, fuel, emergency,
             takeoff_signal, gate_number,
      input  allocated_runway, allocated_gate, timer_active, timer_value
   );

   modport slave (
      input  weather, speed, range, altitude, fuel, emergency,
             takeoff_signal, gate_number,
      output allocated_runway, allocated_gate, timer_active, timer_value
   );

endinterface

// File: rtl/atc_hold_timer.sv
// Loadable 4-bit hold down-counter; sticks at zero until reloaded or cleared.
// Latency: load/clear take effect on the next clock edge.
// Backpressure: none.
//
// Ports: clk, rst_n | load, load_value, clear (clear wins) |
//        active (counter running), expired (running and at zero), value
module atc_hold_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       clear,
   output logic       active,
   output logic       expired,
   output logic [3:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value  <= 4'd0;
         active <= 1'b0;
      end else if (clear) begin
         value  <= 4'd0;
         active <= 1'b0;
      end else if (load) begin
         value  <= load_value;
         active <= 1'b1;
      end else if (active && value != 4'd0) begin
         value  <= value - 4'd1;
      end
   end

   // Remains active at zero so the arbiter sees one expired cycle to act on.
   assign expired = active && (value == 4'd0);

endmodule

// File: rtl/air_traffic_ctrl.sv
// Single-airport runway/gate arbiter: urgent landings immediately on runway 0,
// weather/fuel cases held on a countdown, then runway (and gate) granted.
// Latency: 1 clock request->grant; N+1 clocks for a held request.
// Backpressure: none; one request served at a time, others wait at their inputs.
//
// Ports: clk, rst_n (async, active low), bus (air_traffic_ctrl_if.slave)
module air_traffic_ctrl
   import air_traffic_pkg::*;
#(
   parameter int unsigned WX_HOLD   = 12,
   parameter int unsigned FUEL_HOLD = 15,   // must fit in 4 bits
   parameter int unsigned NUM_GATES = 8
) (
   input logic             clk,
   input logic             rst_n,
   air_traffic_ctrl_if.slave bus
);

   localparam logic [2:0] GATE_MAX = 3'(NUM_GATES - 1);

   atc_state_t state, state_nxt;
   logic [1:0] rwy_q, rwy_nxt;
   logic [2:0] gate_q, gate_nxt;
   logic [1:0] rr_ptr, rr_nxt;
   logic [2:0] gate_ptr, gptr_nxt;
   logic       hold_wx, hold_wx_nxt;    // current hold was caused by weather
   logic       emergency_q;
   logic [2:0] gate_number_q;

   logic       tmr_load, tmr_clear, tmr_active, tmr_expired;
   logic [3:0] tmr_load_val, tmr_value;

   logic       grant_urgent, grant_land, grant_takeoff, start_wx, start_fuel;
   logic       land_req, urgent, req_dropped;

   // Gate 0 means "none", so landing gates rotate 1..GATE_MAX.
   function automatic logic [2:0] next_gate(input logic [2:0] g);
      return (g == GATE_MAX) ? 3'd1 : g + 3'd1;
   endfunction

   assign land_req    = bus.speed & bus.range & bus.altitude & ~bus.takeoff_signal;
   assign urgent      = land_req & (bus.emergency | (bus.fuel == FUEL_SHORT));
   assign req_dropped = ~land_req & ~bus.takeoff_signal;

   atc_hold_timer u_hold_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_load_val),
      .clear      (tmr_clear),
      .active     (tmr_active),
      .expired    (tmr_expired),
      .value      (tmr_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         rwy_q         <= RWY_EMERG;
         gate_q        <= 3'd0;
         rr_ptr        <= RWY_FIRST;
         gate_ptr      <= 3'd1;
         hold_wx       <= 1'b0;
         emergency_q   <= 1'b0;
         gate_number_q <= 3'd0;
      end else begin
         state         <= state_nxt;
         rwy_q         <= rwy_nxt;
         gate_q        <= gate_nxt;
         rr_ptr        <= rr_nxt;
         gate_ptr      <= gptr_nxt;
         hold_wx       <= hold_wx_nxt;
         emergency_q   <= bus.emergency;
         gate_number_q <= bus.gate_number;
      end
   end

   always_comb begin
      state_nxt     = state;
      rwy_nxt       = rwy_q;
      gate_nxt      = gate_q;
      rr_nxt        = rr_ptr;
      gptr_nxt      = gate_ptr;
      hold_wx_nxt   = hold_wx;
      tmr_load      = 1'b0;
      tmr_clear     = 1'b0;
      tmr_load_val  = 4'(WX_HOLD);
      grant_urgent  = 1'b0;
      grant_land    = 1'b0;
      grant_takeoff = 1'b0;
      start_wx      = 1'b0;
      start_fuel    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (urgent)
               grant_urgent = 1'b1;
            else if (bus.takeoff_signal && !bus.weather)
               start_wx = 1'b1;
            else if (bus.takeoff_signal)
               grant_takeoff = 1'b1;
            else if (land_req && !bus.weather)
               start_wx = 1'b1;
            else if (land_req && bus.fuel == FUEL_EXCESS)
               start_fuel = 1'b1;
            else if (land_req)
               grant_land = 1'b1;
         end
         ST_HOLD: begin
            if (urgent) begin
               grant_urgent = 1'b1;
            end else if (req_dropped) begin
               tmr_clear = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tmr_expired) begin
               // Weather holds repeat until the weather clears; fuel holds run once.
               if (hold_wx && !bus.weather)
                  start_wx = 1'b1;
               else if (bus.takeoff_signal)
                  grant_takeoff = 1'b1;
               else
                  grant_land = 1'b1;
            end
         end
         ST_GRANTED: begin
            if (req_dropped)
               state_nxt = ST_IDLE;
            else if (bus.emergency && !emergency_q && rwy_q != RWY_EMERG)
               rwy_nxt = RWY_EMERG;
            else if (bus.takeoff_signal && bus.gate_number != gate_number_q)
               grant_takeoff = 1'b1;   // departing gate moved: re-pick runway
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (start_wx || start_fuel) begin
         tmr_load     = 1'b1;
         tmr_load_val = start_wx ? 4'(WX_HOLD) : 4'(FUEL_HOLD);
         hold_wx_nxt  = start_wx;
         state_nxt    = ST_HOLD;
      end
      if (grant_urgent) begin
         rwy_nxt  = RWY_EMERG;
         gate_nxt = gate_ptr;
         gptr_nxt = next_gate(gate_ptr);
      end
      if (grant_land) begin
         rwy_nxt  = rr_ptr;
         rr_nxt   = next_runway(rr_ptr);
         gate_nxt = gate_ptr;
         gptr_nxt = next_gate(gate_ptr);
      end
      if (grant_takeoff) begin
         rwy_nxt  = gate_to_runway(bus.gate_number);
         gate_nxt = 3'd0;
      end
      if (grant_urgent || grant_land || grant_takeoff) begin
         tmr_clear = 1'b1;
         state_nxt = ST_GRANTED;
      end
   end

   assign bus.allocated_runway = rwy_q;
   assign bus.allocated_gate   = gate_q;
   assign bus.timer_active     = tmr_active;
   assign bus.timer_value      = tmr_value;

endmodule

// File: tb/tb_air_traffic_ctrl.sv
// Directed bench for air_traffic_ctrl: table of single-cycle vectors plus
// hand-written sequences for holds, reloads, aborts and asynchronous reset.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_air_traffic_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   air_traffic_ctrl_if atc ();

   air_traffic_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (atc)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       weather;
      logic       land;
      logic [1:0] fuel;
      logic       emergency;
      logic       takeoff;
      logic [2:0] gate_number;
      logic [1:0] exp_rwy;
      logic [2:0] exp_gate;
      logic       exp_act;
      logic [3:0] exp_val;
   } vec_t;

   vec_t tbl[$];

   task automatic drive(input logic w, input logic land, input logic [1:0] f,
                        input logic e, input logic to, input logic [2:0] gn);
      atc.weather        = w;
      atc.speed          = land;
      atc.range          = land;
      atc.altitude       = land;
      atc.fuel           = f;
      atc.emergency      = e;
      atc.takeoff_signal = to;
      atc.gate_number    = gn;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [1:0] rwy, input logic [2:0] gate,
                             input logic act, input logic [3:0] val);
      check({name, ".runway"}, {2'b00, atc.allocated_runway}, {2'b00, rwy});
      check({name, ".gate"},   {1'b0, atc.allocated_gate},    {1'b0, gate});
      check({name, ".active"}, {3'b000, atc.timer_active},    {3'b000, act});
      check({name, ".value"},  atc.timer_value,               val);
   endtask

   task automatic add(input logic w, input logic land, input logic [1:0] f, input logic e,
                      input logic to, input logic [2:0] gn, input logic [1:0] rwy,
                      input logic [2:0] gate, input logic act, input logic [3:0] val);
      vec_t v;
      v.weather = w;   v.land = land;   v.fuel = f;        v.emergency = e;
      v.takeoff = to;  v.gate_number = gn;
      v.exp_rwy = rwy; v.exp_gate = gate; v.exp_act = act; v.exp_val = val;
      tbl.push_back(v);
   endtask

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) begin
         drive(tbl[i].weather, tbl[i].land, tbl[i].fuel, tbl[i].emergency,
               tbl[i].takeoff, tbl[i].gate_number);
         step();
         check_outs($sformatf("%s[%0d]", tag, i), tbl[i].exp_rwy, tbl[i].exp_gate,
                    tbl[i].exp_act, tbl[i].exp_val);
      end
      tbl.delete();
   endtask

   // Expects the timer to count from 'from' down to zero, one step per cycle.
   task automatic count_down(input string name, input int from, input int wx_restore_at);
      for (int k = from; k >= 0; k--) begin
         if (k == wx_restore_at) atc.weather = 1'b1;
         step();
         check($sformatf("%s.value@%0d", name, k), atc.timer_value, 4'(k));
         check($sformatf("%s.active@%0d", name, k), {3'b000, atc.timer_active}, 4'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive(1, 0, 2'b00, 0, 0, 3'd0);
      #12;
      check_outs("reset", 2'd0, 3'd0, 1'b0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Immediate grants; pointers start at runway 1, gate 1.
      add(1, 1, 2'b00, 1, 0, 3'd0,  2'd0, 3'd1, 0, 4'd0);  // emergency landing
      add(1, 0, 2'b00, 0, 0, 3'd0,  2'd0, 3'd1, 0, 4'd0);  // released, outputs held
      add(1, 1, 2'b01, 0, 0, 3'd0,  2'd0, 3'd2, 0, 4'd0);  // fuel shortage
      add(1, 0, 2'b00, 0, 0, 3'd0,  2'd0, 3'd2, 0, 4'd0);
      add(1, 0, 2'b00, 0, 1, 3'd5,  2'd2, 3'd0, 0, 4'd0);  // takeoff, good weather
      add(1, 0, 2'b00, 0, 0, 3'd0,  2'd2, 3'd0, 0, 4'd0);
      run_tbl("basic");

      // Weather hold, weather restored mid-hold: grant 13 cycles after entry.
      drive(0, 1, 2'b00, 0, 0, 3'd0);
      step();
      check_outs("wx_entry", 2'd2, 3'd0, 1'b1, 4'd12);
      count_down("wx", 11, 6);
      step();
      check_outs("wx_grant", 2'd1, 3'd3, 1'b0, 4'd0);
      drive(1, 0, 2'b00, 0, 0, 3'd0);
      step();
      check_outs("wx_release", 2'd1, 3'd3, 1'b0, 4'd0);

      // Weather still bad at expiry: reload, then request withdrawn.
      drive(0, 1, 2'b00, 0, 0, 3'd0);
      step();
      check_outs("wx2_entry", 2'd1, 3'd3, 1'b1, 4'd12);
      count_down("wx2", 11, -1);
      step();
      check_outs("wx2_reload", 2'd1, 3'd3, 1'b1, 4'd12);
      step();
      check("wx2_after_reload", atc.timer_value, 4'd11);
      drive(0, 0, 2'b00, 0, 0, 3'd0);
      step();
      check_outs("wx2_dropped", 2'd1, 3'd3, 1'b0, 4'd0);

      // Excess fuel: 15-cycle hold, grant 16 cycles after entry.
      drive(1, 1, 2'b10, 0, 0, 3'd0);
      step();
      check_outs("fuel_entry", 2'd1, 3'd3, 1'b1, 4'd15);
      count_down("fuel", 14, -1);
      step();
      check_outs("fuel_grant", 2'd2, 3'd4, 1'b0, 4'd0);
      drive(1, 0, 2'b00, 0, 0, 3'd0);
      step();

      // Emergency aborts a fuel hold.
      drive(1, 1, 2'b10, 0, 0, 3'd0);
      step();
      check_outs("abort_entry", 2'd2, 3'd4, 1'b1, 4'd15);
      step(); step(); step();
      check("abort_mid", atc.timer_value, 4'd12);
      drive(1, 1, 2'b10, 1, 0, 3'd0);
      step();
      check_outs("abort_grant", 2'd0, 3'd5, 1'b0, 4'd0);
      drive(1, 0, 2'b00, 0, 0, 3'd0);
      step();

      // Runway 3, emergency re-grant while granted, gate wrap 7 -> 1.
      add(1, 1, 2'b00, 0, 0, 3'd0,  2'd3, 3'd6, 0, 4'd0);
      add(1, 1, 2'b00, 1, 0, 3'd0,  2'd0, 3'd6, 0, 4'd0);
      add(1, 0, 2'b00, 0, 0, 3'd0,  2'd0, 3'd6, 0, 4'd0);
      add(1, 1, 2'b00, 0, 0, 3'd0,  2'd1, 3'd7, 0, 4'd0);
      add(1, 0, 2'b00, 0, 0, 3'd0,  2'd1, 3'd7, 0, 4'd0);
      add(1, 1, 2'b00, 1, 0, 3'd0,  2'd0, 3'd1, 0, 4'd0);
      add(1, 0, 2'b00, 0, 0, 3'd0,  2'd0, 3'd1, 0, 4'd0);
      run_tbl("regrant");

      // Takeoff in bad weather, then departing gate moves twice.
      drive(0, 0, 2'b00, 0, 1, 3'd1);
      step();
      check_outs("to_entry", 2'd0, 3'd1, 1'b1, 4'd12);
      atc.weather = 1'b1;
      count_down("to", 11, -1);
      step();
      check_outs("to_grant", 2'd1, 3'd0, 1'b0, 4'd0);
      atc.gate_number = 3'd4;
      step();
      check_outs("to_gate4", 2'd2, 3'd0, 1'b0, 4'd0);
      atc.gate_number = 3'd6;
      step();
      check_outs("to_gate6", 2'd3, 3'd0, 1'b0, 4'd0);
      drive(1, 0, 2'b00, 0, 0, 3'd0);
      step();

      // Reset asserted mid-hold clears everything without a clock edge.
      drive(0, 1, 2'b00, 0, 0, 3'd0);
      step();
      check("rst_entry", atc.timer_value, 4'd12);
      step(); step(); step();
      check("rst_mid", atc.timer_value, 4'd9);
      #2;
      rst_n = 1'b0;
      drive(1, 0, 2'b00, 0, 0, 3'd0);
      #1;
      check_outs("async_reset", 2'd0, 3'd0, 1'b0, 4'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Six normal landings from reset: runways 1,2,3,1,2,3; gates 1..6.
      for (int i = 0; i < 6; i++) begin
         add(1, 1, 2'b00, 0, 0, 3'd0, 2'((i % 3) + 1), 3'(i + 1), 0, 4'd0);
         add(1, 0, 2'b00, 0, 0, 3'd0, 2'((i % 3) + 1), 3'(i + 1), 0, 4'd0);
      end
      run_tbl("rotation");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/air_traffic_ctrl.md
Name: air_traffic_ctrl

Overview:
Single-airport runway/gate arbiter for landing and takeoff requests. It grants emergency and low-fuel landings immediately on runway 0. It defers bad-weather and excess-fuel cases with a countdown hold timer, then grants a runway, plus a gate for landings. All outputs are registered and sit directly on the tower status bus.

Parameters:
- WX_HOLD, 12, hold cycles when weather is bad.
- FUEL_HOLD, 15, hold cycles when fuel is excess; must be ≤15 to fit timer_value.
- NUM_GATES, 8, gate count; gate index width is 3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- weather  in  1  1=good, 0=bad
- speed  in  1  1=approach speed within limits
- range  in  1  1=aircraft within landing range
- altitude  in  1  1=approach altitude within limits
- fuel  in  2  00 normal, 01 shortage, 10 excess, 11 reserved (treated as normal)
- emergency  in  1  declared emergency
- takeoff_signal  in  1  1=takeoff request
- gate_number  in  3  departing aircraft's gate
- allocated_runway  out  2  granted runway (0 = emergency runway)
- allocated_gate  out  3  gate granted to a landing aircraft
- timer_active  out  1  hold timer running
- timer_value  out  4  remaining hold cycles

Behaviour:
- Reset (async, rst_n=0): allocated_runway=00, allocated_gate=000, timer_active=0, timer_value=0, FSM=IDLE, runway round-robin pointer=1, gate pointer=1.
- Request decoding:
  - land_req = speed & range & altitude & ~takeoff_signal.
  - urgent = land_req & (emergency | fuel==01).
- FSM states: IDLE, HOLD, GRANTED. Only one request is served at a time.
- IDLE, first matching rule wins:
  - urgent → runway 00, gate=pointer, gate pointer advances, go to GRANTED next cycle.
  - takeoff_signal & weather=0 → load WX_HOLD, go to HOLD.
  - takeoff_signal & weather=1 → runway from gate_number (0–3→01, 4–5→10, 6–7→11), allocated_gate=000, go to GRANTED.
  - land_req & weather=0 → load WX_HOLD, go to HOLD.
  - land_req & fuel==10 → load FUEL_HOLD, go to HOLD.
  - land_req otherwise → runway=round-robin pointer (cycles 1→2→3→1), gate=pointer, both pointers advance, go to GRANTED.
- HOLD:
  - timer_active=1; timer_value decrements by 1 per cycle.
  - urgent aborts the hold: timer cleared, immediate runway-0 grant.
  - Request dropped → timer cleared, back to IDLE.
  - When timer_value reaches 0: if the hold was weather-caused and weather is still 0, reload WX_HOLD; otherwise grant as in IDLE (normal landing rule or takeoff rule). On grant, timer_active=0.
- GRANTED:
  - Outputs hold their values.
  - Return to IDLE when land_req and takeoff_signal are both 0.
  - A change of gate_number while takeoff_signal=1 re-evaluates the takeoff runway next cycle.
  - emergency rising while granted on a non-zero runway re-grants runway 00.
- Gate pointer: counts 1..7, wraps 7→1. Gate 0 is never given to landings and means "released/none".
- Grant latency: 1 clock from qualifying inputs to registered outputs. Hold latency: N+1 clocks.
- Reset mid-hold: timer and FSM clear immediately.

Decomposition:
- Package air_traffic_pkg holds: fuel encodings, runway constants (RWY_EMERG=0), the FSM state enum, and the gate→runway mapping function.
- One sub-module, atc_hold_timer: 4-bit loadable down-counter with load, clear, active and expired outputs.

Test Plan:
- emergency=1, speed/range/altitude=1, weather=1 → next cycle runway=00, gate=001, timer_active=0.
- fuel=01, emergency=0, landing request → runway=00, gate advances to 010.
- weather=0 with landing request → timer_active=1, timer_value counts 12..0. Weather restored before expiry → runway=01 after 13 cycles. Weather still 0 at 0 → timer reloads 12.
- fuel=10 landing → timer_value starts at 15, grant after 16 cycles. Asserting emergency mid-hold → immediate runway 00, timer cleared.
- takeoff_signal=1, gate_number=001, weather=0 → 12-cycle hold, then runway=01. Change gate to 100 → runway=10. Change to 110 → runway=11. allocated_gate=000 throughout.
- rst_n=0 asserted mid-hold → all outputs zero asynchronously. Six normal landings → runways cycle 01,10,11,01,10,11 and gates cycle 1..6.
